video_write_scheduler: RTL and testbench
========================================

VIDEO_WRITE_SCHEDULER -- requirements
Module: video_write_scheduler

Interface
REQ-001 Parameter DEPTH, default 8, number of deferred-write FIFO entries (power of two, 2..32).
REQ-002 Parameter DEFER_LO, default 6'h04, lowest register address treated as a video register.
REQ-003 Parameter DEFER_HI, default 6'h2f, highest register address treated as a video register.
REQ-004 raw_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (asserted when 0, sampled on raw_clk).
REQ-006 cpu_write_enable  in  1  CPU register write strobe, one write per cycle.
REQ-007 cpu_address  in  6  CPU register address.
REQ-008 cpu_data  in  8  CPU write data.
REQ-009 in_hblank  in  1  video horizontal blanking flag.
REQ-010 in_vblank  in  1  video vertical blanking flag.
REQ-011 stall  out  1  FIFO full; the CPU holds its write while this is high.
REQ-012 reg_write_enable  out  1  write strobe to the peripheral register file.
REQ-013 reg_address  out  6  address presented with reg_write_enable.
REQ-014 reg_data  out  8  data presented with reg_write_enable.
REQ-015 pending  out  $clog2(DEPTH)+1  number of queued writes.
REQ-016 overflow  out  1  sticky flag: a write arrived while stall was high.

Function
REQ-017 A write is video-class when DEFER_LO <= cpu_address <= DEFER_HI; all other writes are bypass-class.
REQ-018 A video-class write SHALL be enqueued as {address, data}; it is never issued directly.
REQ-019 A bypass-class write with pending==0 SHALL be issued on the reg_* outputs exactly one cycle later.
REQ-020 A bypass-class write with pending!=0 SHALL be enqueued, so order matches CPU program order.
REQ-021 The FSM has states IDLE and DRAIN; IDLE->DRAIN when (in_hblank|in_vblank) and pending!=0.
REQ-022 In DRAIN, the head entry SHALL be issued each cycle (one per cycle, registered outputs, pending decrements).
REQ-023 DRAIN->IDLE when pending reaches 0 or blanking deasserts; the entry issued on that cycle completes and the rest stay queued.
REQ-024 An enqueue and a dequeue in the same cycle SHALL leave pending unchanged, and the new entry goes behind the head.
REQ-025 An entry enqueued in cycle N is issued no earlier than cycle N+2.
REQ-026 stall = (pending==DEPTH); a write while stall is high SHALL be dropped and overflow set to 1.
REQ-027 overflow is cleared only by reset.
REQ-028 reg_write_enable is high for exactly one cycle per issued write and is never issued for a dropped write.
REQ-029 Read and write pointers wrap modulo DEPTH with no bubble at wrap-around.

Reset
REQ-030 While reset==0: FSM=IDLE, pointers=0, pending=0, stall=0, overflow=0, reg_write_enable=0, reg_address=0, reg_data=0.
REQ-031 Reset asserted mid-DRAIN SHALL discard all queued entries, and no write is issued in the cycle after reset.

Configuration
REQ-032 Macro VIDEO_WRITE_DEFER_EN defined: deferral behaviour as in REQ-017..REQ-029.
REQ-033 Macro undefined: every write is issued one cycle later as in REQ-019, the FIFO is not built, and stall, overflow and pending are tied to 0.

Structure
REQ-034 The shared package holds the register-address constants (video window bounds, WSYNC=6'h02, VSYNC=6'h00) and the FIFO entry type {addr[5:0], data[7:0]}.
REQ-035 The FIFO is a separate sub-module, write_fifo (synchronous, single clock, registered read); the FSM and classification logic stay in video_write_scheduler.

Verification
REQ-036 Enqueue 3 video writes (0x08=0x1E, 0x09=0x44, 0x0e=0xAA) with no blanking -> no reg_write_enable, pending=3; raise in_hblank -> 3 consecutive issues in order, pending=0.
REQ-037 Bypass write 0x30=0x41 with pending=0 -> reg_write_enable one cycle later with addr 0x30, data 0x41.
REQ-038 Queue 0x06=0x10, then bypass 0x30=0x55 -> 0x30 is issued only after 0x06 during blanking.
REQ-039 DEPTH=8: 9 writes with no blanking -> stall high after the 8th, 9th dropped, overflow=1; drain issues exactly 8.
REQ-040 in_hblank high for 2 cycles with pending=5 -> 2 issued, pending=3; the next blanking issues the remaining 3 in order.
REQ-041 Reset low mid-DRAIN with pending=4 -> pending=0, no issue after release; build without VIDEO_WRITE_DEFER_EN -> 0x08 write issued after 1 cycle.

Source files
------------

// File: rtl/video_write_scheduler_pkg.sv
// Shared definitions for the video write scheduler.
//   - Register-address constants: video window bounds, WSYNC and VSYNC strobes.
//   - wr_entry_t: one deferred register write {addr, data}.
//   - sched_state_t: drain FSM states.
//   - in_window(): video-class address test.
package video_write_scheduler_pkg;

  localparam logic [5:0] VIDEO_LO = 6'h04;
  localparam logic [5:0] VIDEO_HI = 6'h2f;
  localparam logic [5:0] WSYNC    = 6'h02;
  localparam logic [5:0] VSYNC    = 6'h00;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } wr_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } sched_state_t;

  function automatic logic in_window(input logic [5:0] addr,
                                     input logic [5:0] lo,
                                     input logic [5:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/write_fifo.sv
// Deferred-write FIFO: single clock, synchronous active-low reset, registered read.
// Built only when VIDEO_WRITE_DEFER_EN is defined.
//   raw_clk  in   clock
//   reset    in   synchronous reset, active low
//   push     in   write wr_data at the tail (caller never pushes when full)
//   wr_data  in   entry to store
//   pop      in   load the head into rd_data and advance (caller never pops when empty)
//   rd_data  out  entry popped on the previous cycle
//   count    out  number of stored entries, 0..DEPTH
// Pointers are $clog2(DEPTH) bits, so they wrap modulo DEPTH without a bubble.
`ifdef VIDEO_WRITE_DEFER_EN
module write_fifo
  import video_write_scheduler_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          raw_clk,
  input  logic          reset,
  input  logic          push,
  input  wr_entry_t     wr_data,
  input  logic          pop,
  output wr_entry_t     rd_data,
  output logic [CW-1:0] count
);

  wr_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // NOTE: storage is deliberately left out of reset; pointers and count define
  // which slots are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge raw_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge value of the others regardless of statement order.
  always_ff @(posedge raw_clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/video_write_scheduler.sv
// Video write scheduler: defers CPU writes to video registers until blanking.
// Optional feature macro: VIDEO_WRITE_DEFER_EN (undefined: plain one-cycle
// pass-through, no FIFO, stall/overflow/pending tied to 0).
//   raw_clk           in   clock
//   reset             in   synchronous reset, active low
//   cpu_write_enable  in   CPU write strobe
//   cpu_address       in   CPU register address
//   cpu_data          in   CPU write data
//   in_hblank         in   horizontal blanking
//   in_vblank         in   vertical blanking
//   stall             out  FIFO full, CPU must hold its write
//   reg_write_enable  out  write strobe to the register file
//   reg_address       out  register address
//   reg_data          out  register data
//   pending           out  queued write count
//   overflow          out  sticky: a write arrived while stalled
module video_write_scheduler
  import video_write_scheduler_pkg::*;
#(
  parameter  int         DEPTH    = 8,
  parameter  logic [5:0] DEFER_LO = VIDEO_LO,
  parameter  logic [5:0] DEFER_HI = VIDEO_HI,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          raw_clk,
  input  logic          reset,
  input  logic          cpu_write_enable,
  input  logic [5:0]    cpu_address,
  input  logic [7:0]    cpu_data,
  input  logic          in_hblank,
  input  logic          in_vblank,
  output logic          stall,
  output logic          reg_write_enable,
  output logic [5:0]    reg_address,
  output logic [7:0]    reg_data,
  output logic [CW-1:0] pending,
  output logic          overflow
);

`ifdef VIDEO_WRITE_DEFER_EN

  sched_state_t  state_q, state_d;
  logic [CW-1:0] count;
  logic          blanking, is_empty, accept, video, enq, deq, direct;
  wr_entry_t     head;
  logic          we_q, from_fifo_q, overflow_q;
  logic [5:0]    byp_addr_q;
  logic [7:0]    byp_data_q;

  assign blanking = in_hblank | in_vblank;
  assign is_empty = (count == '0);
  assign stall    = (count == CW'(DEPTH));
  assign accept   = cpu_write_enable & ~stall;
  assign video    = in_window(cpu_address, DEFER_LO, DEFER_HI);
  // Bypass writes queue behind any pending entry to keep program order.
  assign enq      = accept & (video | ~is_empty);
  assign direct   = accept & ~video & is_empty;

  write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .raw_clk (raw_clk),
    .reset   (reset),
    .push    (enq),
    .wr_data ('{addr: cpu_address, data: cpu_data}),
    .pop     (deq),
    .rd_data (head),
    .count   (count)
  );

  // NOTE: defaults first so no path leaves state_d or deq unassigned, which
  // would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    deq     = 1'b0;
    case (state_q)
      IDLE: begin
        if (blanking && !is_empty) state_d = DRAIN;
      end
      DRAIN: begin
        deq = ~is_empty;
        // Leave once blanking ends or this pop empties the queue; the entry
        // popped on the exit cycle is still issued.
        if (!blanking || is_empty || (count == CW'(1) && !enq)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      from_fifo_q <= 1'b0;
      byp_addr_q  <= '0;
      byp_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= direct | deq;
      from_fifo_q <= deq;
      if (direct) begin
        byp_addr_q <= cpu_address;
        byp_data_q <= cpu_data;
      end
      if (cpu_write_enable && stall) overflow_q <= 1'b1;
    end
  end

  // Direct and FIFO issues are mutually exclusive (direct needs an empty
  // queue, a pop needs a non-empty one), so a registered select suffices.
  assign reg_write_enable = we_q;
  assign reg_address      = from_fifo_q ? head.addr : byp_addr_q;
  assign reg_data         = from_fifo_q ? head.data : byp_data_q;
  assign pending          = count;
  assign overflow         = overflow_q;

`else

  logic unused_cfg;
  assign unused_cfg = &{1'b0, in_hblank, in_vblank, DEFER_LO, DEFER_HI};

  always_ff @(posedge raw_clk) begin
    if (!reset) begin
      reg_write_enable <= 1'b0;
      reg_address      <= '0;
      reg_data         <= '0;
    end else begin
      reg_write_enable <= cpu_write_enable;
      if (cpu_write_enable) begin
        reg_address <= cpu_address;
        reg_data    <= cpu_data;
      end
    end
  end

  assign stall    = 1'b0;
  assign pending  = '0;
  assign overflow = 1'b0;

`endif

endmodule

// File: tb/tb_video_write_scheduler.sv
// Self-checking bench for video_write_scheduler. A queue-based model predicts
// every output each cycle; directed scenarios add literal expectations.
module tb_video_write_scheduler;
  localparam int         DEPTH = 8;
  localparam logic [5:0] LO    = 6'h04;
  localparam logic [5:0] HI    = 6'h2f;

  logic       raw_clk = 1'b0;
  logic       reset = 1'b0;
  logic       cpu_write_enable = 1'b0;
  logic [5:0] cpu_address = '0;
  logic [7:0] cpu_data = '0;
  logic       in_hblank = 1'b0;
  logic       in_vblank = 1'b0;
  logic       stall, reg_write_enable, overflow;
  logic [5:0] reg_address;
  logic [7:0] reg_data;
  logic [3:0] pending;

  video_write_scheduler #(.DEPTH(DEPTH), .DEFER_LO(LO), .DEFER_HI(HI)) dut (
    .raw_clk          (raw_clk),
    .reset            (reset),
    .cpu_write_enable (cpu_write_enable),
    .cpu_address      (cpu_address),
    .cpu_data         (cpu_data),
    .in_hblank        (in_hblank),
    .in_vblank        (in_vblank),
    .stall            (stall),
    .reg_write_enable (reg_write_enable),
    .reg_address      (reg_address),
    .reg_data         (reg_data),
    .pending          (pending),
    .overflow         (overflow)
  );

  always #5 raw_clk = ~raw_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [13:0] mq[$];      // queued {addr,data} in program order
  bit          m_drain = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_we = 1'b0;
  logic [5:0]  m_addr = '0;
  logic [7:0]  m_data = '0;
  bit          m_rst = 1'b1;

  always @(posedge raw_clk) begin : model
    int n;
    bit blank, vid, from_q;
    if (!reset) begin
      mq.delete();
      m_drain = 1'b0; m_ovf = 1'b0; m_we = 1'b0;
      m_addr = '0; m_data = '0; m_rst = 1'b1;
    end else begin
      m_rst  = 1'b0;
      m_we   = 1'b0;
`ifdef VIDEO_WRITE_DEFER_EN
      n      = mq.size();
      blank  = in_hblank || in_vblank;
      vid    = (cpu_address >= LO) && (cpu_address <= HI);
      from_q = m_drain && (n > 0);
      if (from_q) begin
        {m_addr, m_data} = mq.pop_front();
        m_we = 1'b1;
      end
      if (cpu_write_enable) begin
        if (n == DEPTH) m_ovf = 1'b1;
        else if (vid || n > 0) mq.push_back({cpu_address, cpu_data});
        else begin
          m_we = 1'b1; m_addr = cpu_address; m_data = cpu_data;
        end
      end
      // Drain starts when blanking sees a non-empty queue, and continues
      // while blanking lasts and entries remain.
      m_drain = m_drain ? (blank && mq.size() > 0) : (blank && n > 0);
`else
      n = 0; blank = 1'b0; vid = 1'b0; from_q = 1'b0;
      if (cpu_write_enable) begin
        m_we = 1'b1; m_addr = cpu_address; m_data = cpu_data;
      end
`endif
    end
  end

  // ---------------- compare process + issue log ----------------
  bit          cmp_en = 1'b0;
  logic [13:0] log_q[$];

  always @(negedge raw_clk) begin
    if (cmp_en) begin
      check("reg_write_enable", reg_write_enable, m_we);
      if (m_we || m_rst) begin
        check("reg_address", reg_address, m_addr);
        check("reg_data", reg_data, m_data);
      end
      check("pending", pending, mq.size());
      check("stall", stall, mq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      if (reg_write_enable === 1'b1) log_q.push_back({reg_address, reg_data});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge raw_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    cpu_write_enable = 1'b1; cpu_address = a; cpu_data = d;
    cyc();
    cpu_write_enable = 1'b0;
  endtask

  task automatic do_reset();
    cpu_write_enable = 1'b0; in_hblank = 1'b0; in_vblank = 1'b0;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    log_q.delete();
  endtask

  initial begin
    int bl_cnt, sel;
    bit bl_on;

    // Reset state
    reset = 1'b0;
    cyc();
    cmp_en = 1'b1;
    idle(2);
    check("rst_we", reg_write_enable, 1'b0);
    check("rst_addr", reg_address, 6'h00);
    check("rst_data", reg_data, 8'h00);
    check("rst_pending", pending, 4'd0);
    check("rst_stall", stall, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b1;
    log_q.delete();

    // Three video writes, then one hblank drain
    wr(6'h08, 8'h1E); wr(6'h09, 8'h44); wr(6'h0e, 8'hAA);
    idle(2);
`ifdef VIDEO_WRITE_DEFER_EN
    check("v3_no_issue", log_q.size(), 0);
    check("v3_pending", pending, 4'd3);
`endif
    in_hblank = 1'b1; idle(6); in_hblank = 1'b0; idle(2);
    check("v3_count", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check("v3_first", log_q[0], {6'h08, 8'h1E});
      check("v3_second", log_q[1], {6'h09, 8'h44});
      check("v3_third", log_q[2], {6'h0e, 8'hAA});
    end
    check("v3_pending_end", pending, 4'd0);

    // Bypass write with an empty queue: issued one cycle later
    wr(6'h30, 8'h41);
    check("byp_we", reg_write_enable, 1'b1);
    check("byp_addr", reg_address, 6'h30);
    check("byp_data", reg_data, 8'h41);
    idle(2);

    // Bypass queued behind a video write
    log_q.delete();
    wr(6'h06, 8'h10); wr(6'h30, 8'h55);
    idle(2);
`ifdef VIDEO_WRITE_DEFER_EN
    check("order_pending", pending, 4'd2);
    check("order_no_issue", log_q.size(), 0);
`endif
    in_vblank = 1'b1; idle(5); in_vblank = 1'b0; idle(2);
    check("order_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("order_first", log_q[0], {6'h06, 8'h10});
      check("order_second", log_q[1], {6'h30, 8'h55});
    end

    // Fill past DEPTH: ninth write dropped
    do_reset();
    for (int i = 0; i < 8; i++) wr(6'h10 + 6'(i), 8'(i));
`ifdef VIDEO_WRITE_DEFER_EN
    check("full_stall", stall, 1'b1);
`else
    check("full_stall", stall, 1'b0);
`endif
    wr(6'h20, 8'hEE);
    idle(1);
`ifdef VIDEO_WRITE_DEFER_EN
    check("full_overflow", overflow, 1'b1);
    check("full_pending", pending, 4'd8);
`endif
    in_hblank = 1'b1; idle(12); in_hblank = 1'b0; idle(2);
`ifdef VIDEO_WRITE_DEFER_EN
    check("full_issued", log_q.size(), 8);
    check("full_overflow_sticky", overflow, 1'b1);
`else
    check("full_issued", log_q.size(), 9);
`endif
    if (log_q.size() > 7) check("full_eighth", log_q[7], {6'h17, 8'h07});
    check("full_pending_end", pending, 4'd0);

    // Short blanking: partial drain, then remainder in order
    do_reset();
    for (int i = 0; i < 5; i++) wr(6'h04 + 6'(i), 8'hA0 + 8'(i));
    idle(1);
`ifdef VIDEO_WRITE_DEFER_EN
    check("part_pending5", pending, 4'd5);
`endif
    in_hblank = 1'b1; idle(2); in_hblank = 1'b0; idle(3);
`ifdef VIDEO_WRITE_DEFER_EN
    check("part_issued2", log_q.size(), 2);
    check("part_pending3", pending, 4'd3);
`endif
    in_vblank = 1'b1; idle(6); in_vblank = 1'b0; idle(2);
    check("part_issued5", log_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (log_q.size() > i) check("part_order", log_q[i], {6'h04 + 6'(i), 8'hA0 + 8'(i)});

    // Reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 6; i++) wr(6'h0a + 6'(i), 8'h30 + 8'(i));
    in_hblank = 1'b1;
    idle(3);
`ifdef VIDEO_WRITE_DEFER_EN
    check("mid_pending4", pending, 4'd4);
`endif
    reset = 1'b0;
    cyc();
    check("mid_rst_pending", pending, 4'd0);
    check("mid_rst_we", reg_write_enable, 1'b0);
    cyc();
    reset = 1'b1;
    log_q.delete();
    cyc();
    check("mid_after_we", reg_write_enable, 1'b0);
    idle(3);
    check("mid_after_log", log_q.size(), 0);
    check("mid_after_pending", pending, 4'd0);
    in_hblank = 1'b0;

    // Single video-register write
    wr(6'h08, 8'h5A);
`ifdef VIDEO_WRITE_DEFER_EN
    check("v08_we", reg_write_enable, 1'b0);
    check("v08_pending", pending, 4'd1);
`else
    check("v08_we", reg_write_enable, 1'b1);
    check("v08_addr", reg_address, 6'h08);
    check("v08_data", reg_data, 8'h5A);
`endif
    do_reset();

    // Randomized traffic against the model
    bl_cnt = 0; bl_on = 1'b0; sel = 0;
    for (int c = 0; c < 4000; c++) begin
      if (bl_cnt == 0) begin
        bl_on  = !bl_on;
        bl_cnt = bl_on ? int'($urandom_range(1, 10)) : int'($urandom_range(1, 25));
        sel    = int'($urandom_range(0, 2));
      end
      bl_cnt--;
      in_hblank        = bl_on && (sel != 1);
      in_vblank        = bl_on && (sel != 0);
      cpu_write_enable = ($urandom_range(0, 99) < 55);
      cpu_address      = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(3, 48)) : 6'($urandom);
      cpu_data         = 8'($urandom);
      reset            = ($urandom_range(0, 599) != 0);
      cyc();
    end
    cpu_write_enable = 1'b0; reset = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
